// File: rtl/mascota_pkg.sv
// Shared definitions for the mascota input front-end and the fsm_mascota bench.
package mascota_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } chan_state_e;

  localparam int DEBOUNCE_CYCLES_DEF   = 16;
  localparam int LONG_PRESS_CYCLES_DEF = 64;

  // Counter width able to hold values up to and including max.
  function automatic int cnt_w(input int max);
    return $clog2(max) + 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-FF synchronizer plus press/release debounce FSM.
module debounce_channel
  import mascota_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_confirm,
  output logic release_confirm,
  output logic held
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_ff;
  logic          s;
  chan_state_e   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  assign s = sync_ff[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff <= '0;
      state   <= IDLE;
      cnt     <= '0;
    end else begin
      sync_ff <= {sync_ff[0], raw ^ INVERT};
      state   <= state_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    press_confirm   = 1'b0;
    release_confirm = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (s) begin
          state_nx = PRESS_CHK;
          cnt_nx   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx      = HELD;
          cnt_nx        = '0;
          press_confirm = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HELD: begin
        cnt_nx = '0;
        if (!s) begin
          state_nx = REL_CHK;
          cnt_nx   = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx        = IDLE;
          cnt_nx          = '0;
          release_confirm = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // REL_CHK still counts as held so a bouncy release does not restart the long-press timer.
  assign held = (state == HELD) || (state == REL_CHK);

endmodule

// File: rtl/mascota_input_conditioner.sv
// Conditions raw buttons and light sensor into clean A/B/C pulses, test_mode and luz for fsm_mascota.
module mascota_input_conditioner
  import mascota_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  input  logic btn_c_raw,
  input  logic luz_raw,
  output logic a_pulse,
  output logic b_pulse,
  output logic c_pulse,
  output logic test_mode,
  output logic luz_sync
);

  localparam int NUM_BTN = 3;
  localparam int HW      = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_raw, press, release_c, held;
  logic [1:0]         luz_ff;
  logic [HW-1:0]      hold_cnt;
  logic               long_flag, long_now;

  assign btn_raw = {btn_c_raw, btn_b_raw, btn_a_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (BTN_ACTIVE_LOW)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .raw             (btn_raw[i]),
      .press_confirm   (press[i]),
      .release_confirm (release_c[i]),
      .held            (held[i])
    );
  end

  // Hold counter crossing the threshold this edge; a release on the same edge counts as long.
  assign long_now = held[2] && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      luz_ff    <= '0;
      a_pulse   <= 1'b0;
      b_pulse   <= 1'b0;
      c_pulse   <= 1'b0;
      test_mode <= 1'b0;
      long_flag <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      luz_ff  <= {luz_ff[0], luz_raw};
      a_pulse <= press[0];
      b_pulse <= press[1];
      c_pulse <= release_c[2] && !long_flag && !long_now;

      if (press[2])
        hold_cnt <= '0;
      else if (held[2] && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + HW'(1);

      if (long_now)
        test_mode <= ~test_mode;

      if (release_c[2])
        long_flag <= 1'b0;
      else if (long_now)
        long_flag <= 1'b1;
    end
  end

  assign luz_sync = luz_ff[1];

endmodule

// File: tb/tb_mascota_input_conditioner.sv
// Directed bench for mascota_input_conditioner with default parameters.
module tb_mascota_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_a_raw, btn_b_raw, btn_c_raw, luz_raw;
  logic a_pulse, b_pulse, c_pulse, test_mode, luz_sync;

  int n_tests = 0;
  int n_fail  = 0;

  // Window statistics: pulse counts and first cycle index (1-based, 0 = none).
  int cnt_a, cnt_b, cnt_c, idx_a, idx_b, idx_c, tm_chg, tm_idx;

  mascota_input_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .btn_a_raw (btn_a_raw),
    .btn_b_raw (btn_b_raw),
    .btn_c_raw (btn_c_raw),
    .luz_raw   (luz_raw),
    .a_pulse   (a_pulse),
    .b_pulse   (b_pulse),
    .c_pulse   (c_pulse),
    .test_mode (test_mode),
    .luz_sync  (luz_sync)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_window(input int n);
    logic tm_prev;
    tm_prev = test_mode;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    idx_a = 0; idx_b = 0; idx_c = 0;
    tm_chg = 0; tm_idx = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (a_pulse === 1'b1) begin cnt_a++; if (idx_a == 0) idx_a = i; end
      if (b_pulse === 1'b1) begin cnt_b++; if (idx_b == 0) idx_b = i; end
      if (c_pulse === 1'b1) begin cnt_c++; if (idx_c == 0) idx_c = i; end
      if (test_mode !== tm_prev) begin
        tm_chg++;
        if (tm_idx == 0) tm_idx = i;
        tm_prev = test_mode;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_a_raw = 1'b0; btn_b_raw = 1'b0; btn_c_raw = 1'b0; luz_raw = 1'b1;
    step(3);
    chk("rst_a", a_pulse, 0);
    chk("rst_b", b_pulse, 0);
    chk("rst_c", c_pulse, 0);
    chk("rst_tm", test_mode, 0);
    chk("rst_luz", luz_sync, 0);
    luz_raw = 1'b0;
    reset = 1'b1;
    step(3);

    // Clean A press
    btn_a_raw = 1'b1;
    run_window(40);
    chk("a_cnt", cnt_a, 1);
    chk("a_lat", idx_a, 18);
    chk("a_b_quiet", cnt_b, 0);
    chk("a_c_quiet", cnt_c, 0);
    chk("a_tm_quiet", tm_chg, 0);
    btn_a_raw = 1'b0;
    run_window(30);
    chk("a_rel_nopulse", cnt_a, 0);

    // Bouncing B press
    btn_b_raw = 1'b1; step(5);
    btn_b_raw = 1'b0; step(2);
    btn_b_raw = 1'b1; step(5);
    btn_b_raw = 1'b0; step(2);
    chk("b_bounce_quiet", b_pulse, 0);
    btn_b_raw = 1'b1;
    run_window(30);
    chk("b_cnt", cnt_b, 1);
    chk("b_lat", idx_b, 18);
    btn_b_raw = 1'b0;
    step(30);

    // Short C press
    btn_c_raw = 1'b1;
    run_window(30);
    chk("c_short_hold", cnt_c, 0);
    btn_c_raw = 1'b0;
    run_window(30);
    chk("c_short_cnt", cnt_c, 1);
    chk("c_short_lat", idx_c, 18);
    chk("c_short_tm", tm_chg, 0);
    chk("c_short_tm_lvl", test_mode, 0);

    // Long C press toggles test_mode on, then off
    btn_c_raw = 1'b1;
    run_window(100);
    chk("c_long1_tm_idx", tm_idx, 82);
    chk("c_long1_tm_chg", tm_chg, 1);
    chk("c_long1_tm", test_mode, 1);
    chk("c_long1_nopulse", cnt_c, 0);
    btn_c_raw = 1'b0;
    run_window(30);
    chk("c_long1_rel_nopulse", cnt_c, 0);
    chk("c_long1_rel_tm", test_mode, 1);
    btn_c_raw = 1'b1;
    run_window(100);
    chk("c_long2_tm_idx", tm_idx, 82);
    chk("c_long2_tm", test_mode, 0);
    btn_c_raw = 1'b0;
    run_window(30);
    chk("c_long2_rel_nopulse", cnt_c, 0);

    // Simultaneous A and B
    btn_a_raw = 1'b1; btn_b_raw = 1'b1;
    run_window(30);
    chk("ab_a_idx", idx_a, 18);
    chk("ab_b_idx", idx_b, 18);
    chk("ab_a_cnt", cnt_a, 1);
    btn_a_raw = 1'b0; btn_b_raw = 1'b0;
    step(30);

    // Reset in the middle of an A press
    btn_a_raw = 1'b1;
    run_window(10);
    chk("rmid_pre", cnt_a, 0);
    reset = 1'b0;
    step(2);
    chk("rmid_a", a_pulse, 0);
    reset = 1'b1;
    run_window(30);
    chk("rmid_cnt", cnt_a, 1);
    chk("rmid_lat", idx_a, 18);
    btn_a_raw = 1'b0;
    step(30);

    // Light sensor synchronizer
    luz_raw = 1'b1;
    step(); chk("luz_r1", luz_sync, 0);
    step(); chk("luz_r2", luz_sync, 1);
    luz_raw = 1'b0;
    step(); chk("luz_f1", luz_sync, 1);
    step(); chk("luz_f2", luz_sync, 0);
    luz_raw = 1'b1;
    step(3);
    chk("luz_hi", luz_sync, 1);
    reset = 1'b0;
    step();
    chk("luz_rst", luz_sync, 0);
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mascota_input_conditioner.md
Name: mascota_input_conditioner

Overview:
- Upstream front-end for fsm_mascota; turns raw board pushbuttons and the light sensor into clean control signals.
- Feeds fsm_mascota's A, B, C, test and luz inputs.
- A and B arrive as single-cycle action pulses. C is a short-press pulse; a long press on C toggles the test-mode level instead. luz is a synchronized level.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to confirm a press or release (minimum 2).
- LONG_PRESS_CYCLES, 64: cycles C must stay confirmed-pressed, counted from its press confirmation, to count as a long press (must be > DEBOUNCE_CYCLES).
- BTN_ACTIVE_LOW, 0: when 1, raw button pins are inverted before synchronization.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_a_raw  in  1  raw, asynchronous "feed/advance" button.
- btn_b_raw  in  1  raw, asynchronous "sleep" button.
- btn_c_raw  in  1  raw, asynchronous "play" / test-mode button.
- luz_raw  in  1  raw, asynchronous light-sensor digital level.
- a_pulse  out  1  one-cycle pulse on each confirmed A press.
- b_pulse  out  1  one-cycle pulse on each confirmed B press.
- c_pulse  out  1  one-cycle pulse on each confirmed short C press/release.
- test_mode  out  1  level; toggles on each confirmed long C press.
- luz_sync  out  1  2-FF synchronized luz_raw.

Behaviour:
- Reset: while reset==0 at a clk edge, all of the following clear to 0:
  - synchronizer flops and counters;
  - a_pulse, b_pulse, c_pulse, test_mode, luz_sync;
  - every channel FSM returns to IDLE.
- Reset mid-press:
  - the press is discarded and no pulse is emitted;
  - after reset releases, a button still held must pass a full DEBOUNCE_CYCLES count before a pulse fires.
- Synchronizer: each raw input (after optional inversion) goes through two flops. Call the second flop's output s.
- Channel FSM, per button, states IDLE, PRESS_CHK, HELD, REL_CHK; cnt is a $clog2(max)+1-bit counter:
  - IDLE: s==1 -> PRESS_CHK with cnt=1.
  - PRESS_CHK:
    - s==0 -> IDLE, cnt=0 (glitch rejected).
    - cnt==DEBOUNCE_CYCLES-1 and s==1 -> HELD, and the press is confirmed.
    - otherwise cnt++.
  - HELD: s==0 -> REL_CHK with cnt=1.
  - REL_CHK:
    - s==1 -> HELD (release glitch).
    - cnt==DEBOUNCE_CYCLES-1 and s==0 -> IDLE, and the release is confirmed.
    - otherwise cnt++.
- Channel latency: the press confirms on the edge at which s has been 1 for DEBOUNCE_CYCLES consecutive samples. With default parameters, the pulse is high exactly 2+16=18 cycles after a clean raw rising edge.
- A and B: the pulse is registered and high for exactly one cycle on press confirmation. Holding the button produces no further pulses; a new pulse needs release confirmation first.
- C: a hold counter starts at press confirmation and increments every cycle while the channel is in HELD or REL_CHK.
  - The counter reaching LONG_PRESS_CYCLES:
    - toggles test_mode (once per press);
    - sets a long flag.
  - Release confirmation:
    - long flag clear: c_pulse for one cycle;
    - long flag set: no pulse; the flag clears.
- Channels are fully independent. Simultaneous presses on A, B and C each yield their own pulse; the pulses may coincide in the same cycle.
- luz_sync: 2-cycle latency, no debounce.
- Counters saturate and never wrap. The hold counter stops at LONG_PRESS_CYCLES.

Decomposition:
- Shared package mascota_pkg holds:
  - the channel state encoding (IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3);
  - default DEBOUNCE_CYCLES / LONG_PRESS_CYCLES constants, also reused by the fsm_mascota bench.
- One sub-module, debounce_channel, is instantiated three times:
  - contents: synchronizer, FSM and debounce counter;
  - outputs: press_confirm, release_confirm, held.
- Pulse, long-press and test_mode logic lives in the top.

Test Plan:
- Reset, then btn_a_raw held high for 40 cycles -> a_pulse high exactly once, 18 cycles after the raw edge; b_pulse, c_pulse and test_mode stay 0.
- btn_b_raw bouncing (1 for 5, 0 for 2, 1 for 5 cycles), then stable 30 cycles -> exactly one b_pulse, 18 cycles after the start of the final stable-high run.
- btn_c_raw held 30 cycles, then released -> test_mode stays 0; one c_pulse 18 cycles after release.
- btn_c_raw held 100 cycles -> test_mode rises at cycle 2+16+64=82 and c_pulse never fires. A second 100-cycle hold -> test_mode returns to 0.
- btn_a_raw and btn_b_raw rise in the same cycle -> a_pulse and b_pulse both high in the same cycle. reset driven 0 at cycle 10 of a press -> no pulse; after reset releases with the button still held, a pulse 18 cycles later.
- luz_raw toggled -> luz_sync follows 2 cycles later; reset low forces luz_sync=0.
